dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder and the memory stage.
//   dmem_state_t : responder FSM states
//   mem_size_t   : access size encoding (shared with the memory stage)
//   byte_enable  : 8-lane write mask for a size at a byte offset; lanes past
//                  byte 7 are dropped, with no carry into the next word
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RELEASE, WR_WAIT, WR_RELEASE
  } dmem_state_t;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_t;

  function automatic logic [7:0] byte_enable(input mem_size_t size, input logic [2:0] offset);
    logic [15:0] m;
    case (size)
      BYTE:    m = 16'h0001;
      HALF:    m = 16'h0003;
      WORD:    m = 16'h000f;
      default: m = 16'h00ff;
    endcase
    m = m << offset;
    return m[7:0];
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables.
//   clk   : clock
//   we    : write strobe, qualified per lane by be
//   be    : byte-lane enables
//   idx   : word index, shared by read and write
//   wdata : write word (already lane-aligned)
//   rdata : asynchronous read of mem[idx]
// Contents are never cleared.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the memory stage's S_R_* / S_W_* interfaces,
// backed by dmem_ram with programmable read and write latency.
//   clk, reset        : clock, synchronous active-high reset
//   S_R_ADDR/_VALID   : read request, held until S_R_DATA_VALID
//   S_R_DATA/_VALID   : full read word and its one-cycle strobe
//   S_W_VALID/ADDR/DATA/SIZE : write request (data right-justified)
//   S_W_READY         : high in IDLE outside reset
//   S_W_COMPLETE      : one-cycle write-done strobe
//   S_ERR             : misalignment strobe (only with DMEM_ALIGN_CHECK_EN)
// Optional feature macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
  input  logic                  S_R_ADDR_VALID,
  output logic [DATA_WIDTH-1:0] S_R_DATA,
  output logic                  S_R_DATA_VALID,
  input  logic                  S_W_VALID,
  input  logic [ADDR_WIDTH-1:0] S_W_ADDR,
  input  logic [DATA_WIDTH-1:0] S_W_DATA,
  input  logic [1:0]            S_W_SIZE,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic                  S_ERR,
`endif
  output logic                  S_W_READY,
  output logic                  S_W_COMPLETE
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [2:0]            wr_off_q, wr_off_d;
  logic [63:0]           wr_data_q, wr_data_d;
  mem_size_t             wr_size_q, wr_size_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d, wcomp_q, wcomp_d;
  logic                  wr_fire, rd_fire, wr_misalign, ram_we;
  logic [63:0]           ram_rdata;
  logic [IDX_W-1:0]      ram_idx;
  logic                  accept_wr;

  // With a latency of 1 the operation fires in the acceptance cycle itself, so
  // the effective request fields come straight from the ports in IDLE.
  assign accept_wr = (state_q == IDLE) && S_W_VALID;
  assign ram_idx   = (accept_wr || state_q == WR_WAIT) ? wr_idx_d : rd_idx_d;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [2:0] rd_off_q, rd_off_d;
  logic       err_q, err_d;
  assign wr_misalign = (wr_off_d & 3'((4'd1 << wr_size_d) - 4'd1)) != 3'd0;
  assign S_ERR = err_q;
`else
  assign wr_misalign = 1'b0;
`endif

  // Reset wins over a commit that fires in the same cycle.
  assign ram_we = wr_fire && !wr_misalign && !reset;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (byte_enable(wr_size_d, wr_off_d)),
    .idx   (ram_idx),
    .wdata (wr_data_d << {wr_off_d, 3'b000}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_off_d  = wr_off_q;
    wr_data_d = wr_data_q;
    wr_size_d = wr_size_q;
    rd_idx_d  = rd_idx_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    wcomp_d   = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    rd_off_d  = rd_off_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (S_W_VALID) begin
          wr_idx_d  = S_W_ADDR[3 +: IDX_W];
          wr_off_d  = S_W_ADDR[2:0];
          wr_data_d = S_W_DATA;
          wr_size_d = mem_size_t'(S_W_SIZE);
          cnt_d     = 4'(WRITE_LATENCY);
          if (WRITE_LATENCY == 1) begin
            wr_fire = 1'b1;
            state_d = WR_RELEASE;
          end else begin
            state_d = WR_WAIT;
          end
        end else if (S_R_ADDR_VALID) begin
          rd_idx_d = S_R_ADDR[3 +: IDX_W];
`ifdef DMEM_ALIGN_CHECK_EN
          rd_off_d = S_R_ADDR[2:0];
`endif
          cnt_d    = 4'(READ_LATENCY);
          if (READ_LATENCY == 1) begin
            rd_fire = 1'b1;
            state_d = RD_RELEASE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd1) begin
          rd_fire = 1'b1;
          state_d = RD_RELEASE;
        end
      end
      RD_RELEASE: if (!S_R_ADDR_VALID) state_d = IDLE;
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd1) begin
          wr_fire = 1'b1;
          state_d = WR_RELEASE;
        end
      end
      WR_RELEASE: if (!S_W_VALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes and read data are registered at the firing edge.
    if (rd_fire) begin
      rdata_d  = ram_rdata;
      rvalid_d = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
      err_d    = rd_off_d != 3'd0;
`endif
    end
    if (wr_fire) begin
      wcomp_d = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
      err_d   = wr_misalign;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_idx_q  <= '0;
      wr_off_q  <= '0;
      wr_data_q <= '0;
      wr_size_q <= BYTE;
      rd_idx_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wcomp_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      rd_off_q  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_off_q  <= wr_off_d;
      wr_data_q <= wr_data_d;
      wr_size_q <= wr_size_d;
      rd_idx_q  <= rd_idx_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      wcomp_q   <= wcomp_d;
`ifdef DMEM_ALIGN_CHECK_EN
      rd_off_q  <= rd_off_d;
      err_q     <= err_d;
`endif
    end
  end

  assign S_R_DATA       = rdata_q;
  assign S_R_DATA_VALID = rvalid_q;
  assign S_W_COMPLETE   = wcomp_q;
  assign S_W_READY      = (state_q == IDLE) && !reset;

endmodule
